// File: rtl/dfr_axil_cfg_slave_if.sv
// AXI4-Lite bus bundle for the DFR configuration slave.
// The slave modport is used by dfr_axil_cfg_slave; the master modport by a host or testbench.
interface dfr_axil_cfg_slave_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 30,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/dfr_axil_cfg_slave.sv
// AXI4-Lite configuration/memory-window slave for the DFR core.
// addr[27:24]: 0 = register bank (CTRL, DEBUG, seven RW config words),
// 1..4 = memory windows forwarded to the req/ack memory port, 5..15 = DECERR.
// Optional build macro DFR_AXIL_MEM_TIMEOUT_EN adds a memory ack timeout
// (MEM_TIMEOUT_CYCLES) answered with SLVERR; without it the slave waits for ack forever.
// READY outputs are registered and predicted one cycle ahead, so they are only
// ever high while the FSM sits in IDLE.
module dfr_axil_cfg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 30,
  parameter int MEM_ADDR_WIDTH     = 16,
  parameter int MEM_TIMEOUT_CYCLES = 256
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESET,
  dfr_axil_cfg_slave_if.slave       s_axi,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [1:0]                mem_sel,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ack,
  input  logic                      core_busy,
  input  logic                      core_done,
  input  logic [31:0]               debug_in,
  output logic                      ctrl_start,
  output logic [223:0]              cfg_flat
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_WR = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_WRESP  = 3'd3,
    ST_RRESP  = 3'd4
  } state_t;

  state_t state_r, state_nx_s;

  logic                          awready_r, awready_nx_s;
  logic                          arready_r, arready_nx_s;
  logic                          bvalid_r, bvalid_nx_s;
  logic [1:0]                    bresp_r, bresp_nx_s;
  logic                          rvalid_r, rvalid_nx_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r, rdata_nx_s;
  logic [1:0]                    rresp_r, rresp_nx_s;
  logic                          mem_req_r, mem_req_nx_s;
  logic                          mem_we_r, mem_we_nx_s;
  logic [1:0]                    mem_sel_r, mem_sel_nx_s;
  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_r, mem_addr_nx_s;
  logic [31:0]                   mem_wdata_r, mem_wdata_nx_s;

  logic        go_r;
  logic        ctrl_start_r;
  logic [31:0] cfg_r [7];

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_s, ar_addr_s;
  logic [3:0]                    aw_region_s, ar_region_s;
  logic                          aw_is_mem_s, ar_is_mem_s;
  logic [5:0]                    aw_idx_s, ar_idx_s;
  logic [2:0]                    cfg_sel_s;
  logic                          aw_hs_s, ar_hs_s;
  logic                          reg_wr_s, start_wr_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] reg_rdata_s;
  logic                          tmo_hit_s;
  logic                          unused_s;

  assign aw_addr_s   = s_axi.S_AXI_AWADDR;
  assign ar_addr_s   = s_axi.S_AXI_ARADDR;
  assign aw_region_s = aw_addr_s[27:24];
  assign ar_region_s = ar_addr_s[27:24];
  assign aw_is_mem_s = (aw_region_s >= 4'd1) && (aw_region_s <= 4'd4);
  assign ar_is_mem_s = (ar_region_s >= 4'd1) && (ar_region_s <= 4'd4);
  assign aw_idx_s    = aw_addr_s[7:2];
  assign ar_idx_s    = ar_addr_s[7:2];
  assign cfg_sel_s   = 3'(ar_idx_s - 6'd2);
  assign unused_s    = ^{aw_addr_s, ar_addr_s};

  // AWREADY and WREADY share one register: both channels are accepted together.
  assign aw_hs_s    = awready_r && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
  assign ar_hs_s    = arready_r && s_axi.S_AXI_ARVALID;
  assign reg_wr_s   = aw_hs_s && (aw_region_s == 4'd0);
  assign start_wr_s = reg_wr_s && (aw_idx_s == 6'd0) && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[0];

`ifdef DFR_AXIL_MEM_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;

  assign tmo_hit_s = (tmo_cnt_r == 32'(MEM_TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting for mem_ack; cleared whenever the memory state is left.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      tmo_cnt_r <= 32'd0;
    end else if (((state_r == ST_MEM_WR) || (state_r == ST_MEM_RD)) && (state_nx_s == state_r)) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_r <= 32'd0;
    end
  end
`else
  localparam int tmo_cycles_unused = MEM_TIMEOUT_CYCLES;
  assign tmo_hit_s = 1'b0;
`endif

  // Register-bank read mux, indexed by the read address word offset.
  always_comb begin
    reg_rdata_s = 32'd0;
    case (ar_idx_s)
      6'd0:    reg_rdata_s = {30'd0, core_busy, go_r};
      6'd1:    reg_rdata_s = debug_in;
      6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8:
               reg_rdata_s = cfg_r[cfg_sel_s];
      default: reg_rdata_s = 32'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and next-output logic; outputs hold unless a transition updates them.
  always_comb begin
    state_nx_s     = state_r;
    awready_nx_s   = 1'b0;
    arready_nx_s   = 1'b0;
    bvalid_nx_s    = bvalid_r;
    bresp_nx_s     = bresp_r;
    rvalid_nx_s    = rvalid_r;
    rdata_nx_s     = rdata_r;
    rresp_nx_s     = rresp_r;
    mem_req_nx_s   = mem_req_r;
    mem_we_nx_s    = mem_we_r;
    mem_sel_nx_s   = mem_sel_r;
    mem_addr_nx_s  = mem_addr_r;
    mem_wdata_nx_s = mem_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (aw_hs_s) begin
          if (aw_region_s == 4'd0) begin
            state_nx_s  = ST_WRESP;
            bvalid_nx_s = 1'b1;
            bresp_nx_s  = RESP_OKAY;
          end else if (aw_is_mem_s) begin
            if (s_axi.S_AXI_WSTRB == 4'hF) begin
              state_nx_s     = ST_MEM_WR;
              mem_req_nx_s   = 1'b1;
              mem_we_nx_s    = 1'b1;
              mem_sel_nx_s   = 2'(aw_region_s - 4'd1);
              mem_addr_nx_s  = aw_addr_s[MEM_ADDR_WIDTH+1:2];
              mem_wdata_nx_s = s_axi.S_AXI_WDATA;
            end else begin
              // Partial-word memory writes are refused without touching the memory.
              state_nx_s  = ST_WRESP;
              bvalid_nx_s = 1'b1;
              bresp_nx_s  = RESP_SLVERR;
            end
          end else begin
            state_nx_s  = ST_WRESP;
            bvalid_nx_s = 1'b1;
            bresp_nx_s  = RESP_DECERR;
          end
        end else if (ar_hs_s) begin
          if (ar_region_s == 4'd0) begin
            state_nx_s  = ST_RRESP;
            rvalid_nx_s = 1'b1;
            rdata_nx_s  = reg_rdata_s;
            rresp_nx_s  = RESP_OKAY;
          end else if (ar_is_mem_s) begin
            state_nx_s    = ST_MEM_RD;
            mem_req_nx_s  = 1'b1;
            mem_we_nx_s   = 1'b0;
            mem_sel_nx_s  = 2'(ar_region_s - 4'd1);
            mem_addr_nx_s = ar_addr_s[MEM_ADDR_WIDTH+1:2];
          end else begin
            state_nx_s  = ST_RRESP;
            rvalid_nx_s = 1'b1;
            rdata_nx_s  = 32'd0;
            rresp_nx_s  = RESP_DECERR;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MEM_WR: begin
        if (mem_ack) begin
          state_nx_s   = ST_WRESP;
          mem_req_nx_s = 1'b0;
          mem_we_nx_s  = 1'b0;
          bvalid_nx_s  = 1'b1;
          bresp_nx_s   = RESP_OKAY;
        end else if (tmo_hit_s) begin
          state_nx_s   = ST_WRESP;
          mem_req_nx_s = 1'b0;
          mem_we_nx_s  = 1'b0;
          bvalid_nx_s  = 1'b1;
          bresp_nx_s   = RESP_SLVERR;
        end else begin
          state_nx_s = ST_MEM_WR;
        end
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          state_nx_s   = ST_RRESP;
          mem_req_nx_s = 1'b0;
          rvalid_nx_s  = 1'b1;
          rdata_nx_s   = mem_rdata;
          rresp_nx_s   = RESP_OKAY;
        end else if (tmo_hit_s) begin
          state_nx_s   = ST_RRESP;
          mem_req_nx_s = 1'b0;
          rvalid_nx_s  = 1'b1;
          rdata_nx_s   = 32'hDEAD_DEAD;
          rresp_nx_s   = RESP_SLVERR;
        end else begin
          state_nx_s = ST_MEM_RD;
        end
      end
      ST_WRESP: begin
        if (s_axi.S_AXI_BREADY) begin
          state_nx_s  = ST_IDLE;
          bvalid_nx_s = 1'b0;
        end else begin
          state_nx_s = ST_WRESP;
        end
      end
      ST_RRESP: begin
        if (s_axi.S_AXI_RREADY) begin
          state_nx_s  = ST_IDLE;
          rvalid_nx_s = 1'b0;
        end else begin
          state_nx_s = ST_RRESP;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        bvalid_nx_s  = 1'b0;
        rvalid_nx_s  = 1'b0;
        mem_req_nx_s = 1'b0;
        mem_we_nx_s  = 1'b0;
      end
    endcase
    // Ready is presented only while idle next cycle; a pending write beats a read.
    if (state_nx_s == ST_IDLE) begin
      awready_nx_s = s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
      arready_nx_s = s_axi.S_AXI_ARVALID && !(s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID);
    end else begin
      awready_nx_s = 1'b0;
      arready_nx_s = 1'b0;
    end
  end

  // Registered bus and memory-port outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_r   <= 1'b0;
      arready_r   <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'b00;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'd0;
      rresp_r     <= 2'b00;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_sel_r   <= 2'd0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'd0;
    end else begin
      awready_r   <= awready_nx_s;
      arready_r   <= arready_nx_s;
      bvalid_r    <= bvalid_nx_s;
      bresp_r     <= bresp_nx_s;
      rvalid_r    <= rvalid_nx_s;
      rdata_r     <= rdata_nx_s;
      rresp_r     <= rresp_nx_s;
      mem_req_r   <= mem_req_nx_s;
      mem_we_r    <= mem_we_nx_s;
      mem_sel_r   <= mem_sel_nx_s;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
    end
  end

  // Register bank writes: START latch with done-priority, byte-enabled config words.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      go_r         <= 1'b0;
      ctrl_start_r <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        cfg_r[i] <= 32'd0;
      end
    end else begin
      ctrl_start_r <= 1'b0;
      if (core_done) begin
        go_r <= 1'b0;
      end else if (start_wr_s && !go_r) begin
        go_r         <= 1'b1;
        ctrl_start_r <= 1'b1;
      end
      for (int i = 0; i < 7; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (reg_wr_s && (aw_idx_s == 6'(i + 2)) && s_axi.S_AXI_WSTRB[b]) begin
            cfg_r[i][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < 7; g++) begin : g_cfg_flat
    assign cfg_flat[32*g +: 32] = cfg_r[g];
  end

  assign s_axi.S_AXI_AWREADY = awready_r;
  assign s_axi.S_AXI_WREADY  = awready_r;
  assign s_axi.S_AXI_BVALID  = bvalid_r;
  assign s_axi.S_AXI_BRESP   = bresp_r;
  assign s_axi.S_AXI_ARREADY = arready_r;
  assign s_axi.S_AXI_RVALID  = rvalid_r;
  assign s_axi.S_AXI_RDATA   = rdata_r;
  assign s_axi.S_AXI_RRESP   = rresp_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_sel    = mem_sel_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign ctrl_start = ctrl_start_r;

endmodule

// File: doc/dfr_axil_cfg_slave.md
Name: dfr_axil_cfg_slave

Overview:
AXI4-Lite responder that terminates the host-side configuration and memory-window traffic for the DFR core. It holds the control register, the debug register and the sample/step count registers. It also decodes the four memory windows (input, reservoir output, weight, DFR output) onto a single req/ack memory port. It sits between the processor AXI interconnect and the DFR core datapath/memories.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 30, AXI address width.
- MEM_ADDR_WIDTH, 16, word-index width of the memory port.
- MEM_TIMEOUT_CYCLES, 256, memory ack timeout. Used only when the optional feature is compiled in.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  reset, synchronous, active-high
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWVALID  in  1
- S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32
- S_AXI_WSTRB  in  4
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2
- S_AXI_BVALID  out  1
- S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1
- S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32
- S_AXI_RRESP  out  2
- S_AXI_RVALID  out  1
- S_AXI_RREADY  in  1
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write
- mem_sel  out  2  0 input, 1 reservoir, 2 weight, 3 output
- mem_addr  out  MEM_ADDR_WIDTH  word index
- mem_wdata  out  32
- mem_rdata  in  32
- mem_ack  in  1  access complete; mem_rdata valid this cycle
- core_busy  in  1  DFR core running
- core_done  in  1  one-cycle done pulse from the core
- debug_in  in  32  value returned for DEBUG reads
- ctrl_start  out  1  one-cycle start pulse
- cfg_flat  out  224  seven 32-bit registers, offsets 0x08..0x20; register at 0x08 in bits [31:0], ascending.

Behaviour:
- Reset values: all READY/VALID outputs 0, BRESP/RRESP 00, RDATA 0, CTRL 0, cfg_flat 0, mem_req/mem_we 0, ctrl_start 0. FSM goes to IDLE.
- Reset mid-transaction: drop mem_req and discard any pending response.
- FSM states:
  - IDLE: on AWVALID&WVALID, assert AWREADY and WREADY together for 1 cycle. Otherwise on ARVALID, assert ARREADY for 1 cycle. Write has priority when both are pending.
  - Decode the address in the accept cycle: register access goes to WRESP/RRESP; memory access goes to MEM_WR/MEM_RD; undecoded address goes to WRESP/RRESP with DECERR.
  - MEM_WR / MEM_RD: mem_req=1 with mem_addr/mem_wdata/mem_we/mem_sel held stable until the cycle mem_ack=1. On ack, drop mem_req and capture mem_rdata; go to WRESP or RRESP the next cycle.
  - WRESP: BVALID held until BREADY, then return to IDLE.
  - RRESP: RVALID, RDATA and RRESP held stable until RREADY, then return to IDLE.
- Only one outstanding transaction. No READY is asserted outside IDLE.
- Latency:
  - Register access: response VALID asserts the cycle after the address handshake.
  - Memory access: response VALID asserts the cycle after mem_ack. mem_ack is legal no earlier than 1 cycle after mem_req rises.
- Address decode uses addr[27:24]:
  - 0 selects registers, indexed by addr[7:2].
  - 1..4 select a memory, with mem_sel = addr[27:24]-1 and mem_addr = addr[MEM_ADDR_WIDTH+1:2].
  - 5..15 return DECERR (11), with RDATA 0 and no mem_req.
- Registers:
  - 0x00 CTRL: bit0 START (RW), bit1 = core_busy (RO), other bits read 0.
  - Writing bit0=1 while CTRL[0]=0 sets CTRL[0] and pulses ctrl_start the next cycle.
  - Writing bit0=1 while CTRL[0]=1 produces no pulse. Writing bit0=0 does not clear CTRL[0].
  - core_done clears CTRL[0]. If core_done and a START write occur in the same cycle, done wins and there is no pulse.
  - 0x04 DEBUG: read-only, returns debug_in. Writes are ignored with OKAY.
  - 0x08–0x20: RW, byte-enabled by WSTRB.
  - Other offsets up to 0xFC: reads return 0 OKAY, writes ignored OKAY.
- Memory writes are full-word only. WSTRB != 4'hF gives SLVERR (10) with no mem_req issued.

Optional Feature:
- Macro: DFR_AXIL_MEM_TIMEOUT_EN.
- Defined: a cycle counter runs in MEM_WR/MEM_RD. If mem_ack is absent for MEM_TIMEOUT_CYCLES cycles:
  - drop mem_req;
  - respond SLVERR, with RDATA=32'hDEAD_DEAD on reads;
  - return to IDLE after the response handshake.
  - A later ack for that access is ignored.
- Undefined: the block waits indefinitely for mem_ack and no counter is present.

Test Plan:
- Write 100 to 0x14, then read 0x14 → BVALID 1 cycle after AW/W handshake, BRESP=00; RDATA=100, RRESP=00.
- Write 0x1 to 0x00 with core_busy=1 → one ctrl_start pulse; read 0x00 gives 0x3. Pulse core_done, drop busy → read gives 0x0. A second START write while running gives no pulse.
- Write 1200 to 0x0100_0008 with a memory model acking after 3 cycles → mem_sel=0, mem_addr=2, mem_we=1, mem_wdata=1200. BVALID the cycle after ack. Read back → 1200.
- Read 0x0500_0000 → RRESP=11, RDATA=0, mem_req never asserted. Write 0x0300_0000 with WSTRB=4'h3 → BRESP=10, no mem_req.
- Hold RREADY low 5 cycles after a register read while AWVALID/WVALID are asserted → RVALID/RDATA stable, AWREADY stays 0 until the R handshake, write accepted the cycle after.
- With DFR_AXIL_MEM_TIMEOUT_EN and MEM_TIMEOUT_CYCLES=16, read 0x0200_0000 with no ack → mem_req drops after 16 cycles, RRESP=10, RDATA=32'hDEAD_DEAD.
